// File: rtl/pe_set_ifmap_loader.sv
// Streams P*Q ifmap words per PE set into NUM_SETS scratchpads; write path is 1 cycle after accept.
// Backpressure: in_ready only while loading; in_valid gaps simply hold counters.
module pe_set_ifmap_loader #(
  parameter int DATA_W   = 16,
  parameter int P        = 3,
  parameter int Q        = 4,
  parameter int NUM_SETS = 4,
  localparam int LOAD_N  = P * Q,
  localparam int CNT_W   = (LOAD_N > 1) ? $clog2(LOAD_N) : 1,
  localparam int SET_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   ifmap_wdata,
  output logic [CNT_W-1:0]    ifmap_waddr,
  output logic [NUM_SETS-1:0] ifmap_we,
  output logic [SET_W-1:0]    set_idx,
  output logic                set_done,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_N - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(NUM_SETS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             drain;
  logic             accept;
  logic             last_word;
  logic             last_set;

  // drain marks the cycle the final write is on the outputs, so done lands one cycle later
  assign in_ready  = (state == LOAD) && !drain;
  assign accept    = in_valid && in_ready;
  assign last_word = (cnt == CNT_LAST);
  assign last_set  = (set_idx == SET_LAST);
  assign busy      = (state == LOAD);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (drain) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      set_idx     <= '0;
      drain       <= 1'b0;
      ifmap_we    <= '0;
      ifmap_waddr <= '0;
      ifmap_wdata <= '0;
      set_done    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ifmap_we <= '0;
      set_done <= 1'b0;
      if (state != LOAD) begin
        cnt     <= '0;
        set_idx <= '0;
        drain   <= 1'b0;
      end else if (accept) begin
        ifmap_we    <= NUM_SETS'(1) << set_idx;
        ifmap_waddr <= cnt;
        ifmap_wdata <= in_data;
        set_done    <= last_word;
        if (last_word) begin
          cnt <= '0;
          if (last_set) drain   <= 1'b1;
          else          set_idx <= set_idx + SET_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_set_ifmap_loader.sv
// Directed bench for pe_set_ifmap_loader: default geometry plus a 1x1x1 instance.
module tb_pe_set_ifmap_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] ifmap_wdata;
  logic [3:0]  ifmap_waddr;
  logic [3:0]  ifmap_we;
  logic [1:0]  set_idx;
  logic        set_done, busy, done;

  logic        start1, in_valid1;
  logic [15:0] in_data1;
  logic        in_ready1;
  logic [15:0] ifmap_wdata1;
  logic [0:0]  ifmap_waddr1;
  logic [0:0]  ifmap_we1;
  logic [0:0]  set_idx1;
  logic        set_done1, busy1, done1;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [24:0] wr_q[$];
  int n_wr, first_wr, last_wr, done_cnt, done_cyc, sd_bad;
  logic busy_at_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pe_set_ifmap_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ifmap_wdata(ifmap_wdata), .ifmap_waddr(ifmap_waddr),
    .ifmap_we(ifmap_we), .set_idx(set_idx), .set_done(set_done), .busy(busy), .done(done)
  );

  pe_set_ifmap_loader #(.DATA_W(16), .P(1), .Q(1), .NUM_SETS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .ifmap_wdata(ifmap_wdata1), .ifmap_waddr(ifmap_waddr1),
    .ifmap_we(ifmap_we1), .set_idx(set_idx1), .set_done(set_done1), .busy(busy1), .done(done1)
  );

  always @(negedge clk) begin
    if (ifmap_we != 4'd0) begin
      wr_q.push_back({ifmap_we, ifmap_waddr, ifmap_wdata, set_done});
      if (n_wr == 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
    end
    if (set_done && ifmap_we == 4'd0) sd_bad++;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    wr_q.delete();
    n_wr = 0; first_wr = 0; last_wr = 0;
    done_cnt = 0; done_cyc = 0; sd_bad = 0; busy_at_done = 1'b1;
  endtask

  // leaves the caller at the negedge of the first LOAD cycle
  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: in_valid held high; mode 1: in_valid alternates 1,0. s1/s2: iterations with start=1
  task automatic feed(input int n, input int mode, input int s1, input int s2);
    int  k  = 0;
    int  it = 0;
    logic acc;
    while (k < n && it < 400) begin
      in_valid = (mode == 0) ? 1'b1 : (it % 2 == 0);
      in_data  = 16'h1000 + k[15:0];
      start    = (it == s1 || it == s2);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
      it++;
      @(negedge clk);
    end
    if (k < n) chk("feed_timeout", k, n);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int mode);
    logic [3:0]  ew, ea;
    logic [15:0] ed;
    logic        es;
    chk({tag, "_wr_count"}, n_wr, 48);
    for (int j = 0; j < 48 && j < wr_q.size(); j++) begin
      ew = 4'b0001 << (j / 12);
      ea = 4'(j % 12);
      ed = 16'h1000 + 16'(j);
      es = (j % 12 == 11);
      chk($sformatf("%s_wr%0d", tag, j), {7'd0, wr_q[j]}, {7'd0, ew, ea, ed, es});
    end
    chk({tag, "_sd_alone"}, sd_bad, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_lat"}, done_cyc - last_wr, 1);
    chk({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 0);
    if (mode == 0) chk({tag, "_consecutive"}, last_wr - first_wr, 47);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {ifmap_we, ifmap_waddr, ifmap_wdata, set_idx, set_done, done, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_outs1", {ifmap_we1, ifmap_waddr1, ifmap_wdata1, set_idx1, set_done1, done1, busy1, in_ready1}, 0);
    rst = 1'b0; in_valid = 1'b0;

    clear_mon();
    start_run();
    chk("load_busy", {31'd0, busy}, 1);
    feed(48, 0, -1, -1);
    wait_done();
    check_run("full", 0);

    clear_mon();
    start_run();
    feed(48, 1, -1, -1);
    wait_done();
    check_run("bubble", 1);

    clear_mon();
    start_run();
    feed(17, 0, -1, -1);
    chk("mid_set_idx", set_idx, 1);
    chk("mid_we", ifmap_we, 4'b0010);
    chk("mid_waddr", ifmap_waddr, 4);
    chk("mid_wdata", ifmap_wdata, 16'h1010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, in_ready}, 0);
    chk("mid_rst_outs", {ifmap_we, ifmap_waddr, ifmap_wdata, set_idx, set_done, done, busy}, 0);
    clear_mon();
    start_run();
    feed(48, 0, -1, -1);
    wait_done();
    check_run("restart", 0);

    clear_mon();
    start_run();
    feed(48, 0, 3, 20);
    @(negedge clk);
    chk("ign_done_state", {31'd0, done}, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_idle_ready", {31'd0, in_ready}, 0);
    repeat (3) @(negedge clk);
    chk("ign_idle_busy", {31'd0, busy}, 0);
    check_run("ignstart", 0);

    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    in_valid1 = 1'b1;
    in_data1 = 16'hA5A5;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("tiny_we", ifmap_we1, 1);
    chk("tiny_waddr", ifmap_waddr1, 0);
    chk("tiny_wdata", ifmap_wdata1, 16'hA5A5);
    chk("tiny_set_done", {31'd0, set_done1}, 1);
    chk("tiny_no_early_done", {31'd0, done1}, 0);
    @(negedge clk);
    chk("tiny_done", {31'd0, done1}, 1);
    chk("tiny_we_off", ifmap_we1, 0);
    chk("tiny_busy_off", {31'd0, busy1}, 0);
    @(negedge clk);
    chk("tiny_done_pulse", {31'd0, done1}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
